// File: rtl/store_monitor_pkg.sv
// Shared types and constants for the store monitor: FSM state encoding,
// default verdict addresses/data and counter widths.
package store_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PASS = 3'd2,
        FAIL = 3'd3,
        TOUT = 3'd4
    } state_e;

    localparam logic [31:0] DEF_PASS_ADDR   = 32'd100;
    localparam logic [31:0] DEF_PASS_DATA   = 32'd25;
    localparam logic [31:0] DEF_IGNORE_ADDR = 32'd96;
    localparam int          DEF_TIMEOUT     = 1000;

    localparam int CNT_W = 16;
    localparam int TMO_W = 20;

    // A verdict state holds until reset.
    function automatic logic is_terminal(input state_e s);
        return (s == PASS) || (s == FAIL) || (s == TOUT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter
    import store_monitor_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; increment stops at the maximum value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/store_monitor.sv
// Watches processor stores and latches a pass / fail / timeout verdict.
// A store of PASS_DATA to PASS_ADDR passes, stores to IGNORE_ADDR are only
// counted, any other store fails, and running TIMEOUT cycles without a
// verdict times out.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR   = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter logic [31:0] IGNORE_ADDR = DEF_IGNORE_ADDR,
    parameter int          TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_data
);

    // Cycle count value seen on the last allowed RUN cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e state_q;
    state_e state_d;

    logic             start_run;
    logic             in_run;
    logic             store_run;
    logic             pass_match;
    logic             bad_store;
    logic             tmo_hit;
    logic [TMO_W-1:0] cyc_cnt;

    logic        done_q,      done_d;
    logic        pass_q,      pass_d;
    logic        fail_q,      fail_d;
    logic        timeout_q,   timeout_d;
    logic [31:0] fail_addr_q, fail_addr_d;
    logic [31:0] fail_data_q, fail_data_d;

    assign start_run  = (state_q == IDLE) && en;
    assign in_run     = (state_q == RUN);
    assign store_run  = in_run && MemWrite;
    assign pass_match = (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
    // A wrong value at the pass address fails even if it aliases the scratch address.
    assign bad_store  = !pass_match && ((DataAdr == PASS_ADDR) || (DataAdr != IGNORE_ADDR));
    assign tmo_hit    = (cyc_cnt == TMO_LAST);

    // Stores seen in RUN, saturating; never cleared except by reset or a new run.
    sat_counter #(.W(CNT_W)) u_store_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_run),
        .inc   (store_run),
        .cnt   (store_count)
    );

    // RUN cycles since the run started.
    sat_counter #(.W(TMO_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_run),
        .inc   (in_run),
        .cnt   (cyc_cnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a store outranks the timeout; a scratch store on the last cycle still times out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (MemWrite && pass_match) begin
                    state_d = PASS;
                end else if (MemWrite && bad_store) begin
                    state_d = FAIL;
                end else if (tmo_hit) begin
                    state_d = TOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Verdict outputs decoded from the next state so they register alongside it.
    always_comb begin
        done_d      = is_terminal(state_d);
        pass_d      = (state_d == PASS);
        fail_d      = (state_d == FAIL);
        timeout_d   = (state_d == TOUT);
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (in_run && (state_d == FAIL)) begin
            fail_addr_d = DataAdr;
            fail_data_d = WriteData;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter PASS_ADDR, default 32'd100: store address that signals a successful program run.
REQ-002 Parameter PASS_DATA, default 32'd25: data value required with PASS_ADDR for a pass.
REQ-003 Parameter IGNORE_ADDR, default 32'd96: scratch address; stores to it are counted, never judged.
REQ-004 Parameter TIMEOUT, default 1000: RUN cycles allowed before a timeout verdict; legal range 1 to 2^20-1.
REQ-005 Port list:
  - clk  input  1  single clock, rising-edge.
  - reset  input  1  synchronous, active-high.
  - en  input  1  arms the monitor.
  - MemWrite  input  1  store strobe from the processor top level.
  - DataAdr  input  32  store address.
  - WriteData  input  32  store data.
  - done  output  1  verdict reached (sticky).
  - pass  output  1  pass verdict.
  - fail  output  1  bad-store verdict.
  - timeout  output  1  timeout verdict.
  - store_count  output  16  stores observed in RUN, saturating.
  - fail_addr  output  32  address of the offending store.
  - fail_data  output  32  data of the offending store.

Function
REQ-006 The FSM SHALL have the states IDLE, RUN, PASS, FAIL and TOUT, all registered on the rising edge of clk.
REQ-007 IDLE SHALL go to RUN on the edge where en=1; otherwise it stays in IDLE, and stores seen in IDLE are ignored and not counted.
REQ-008 In RUN, a store with MemWrite=1, DataAdr==PASS_ADDR and WriteData==PASS_DATA SHALL go to PASS.
REQ-009 In RUN, a store with MemWrite=1 and DataAdr==PASS_ADDR but WriteData!=PASS_DATA SHALL go to FAIL.
REQ-010 In RUN, a store with MemWrite=1 and DataAdr!=IGNORE_ADDR that does not match the REQ-008 pass condition SHALL go to FAIL.
REQ-011 On entry to FAIL, fail_addr and fail_data SHALL capture the offending store's DataAdr and WriteData.
REQ-012 In RUN, a store to IGNORE_ADDR SHALL increment store_count only.
REQ-013 Every store sampled in RUN, including the verdict store, SHALL increment store_count, saturating at 16'hFFFF with no wrap.
REQ-014 A 20-bit cycle counter SHALL clear on IDLE->RUN and increment each RUN cycle.
REQ-015 If the cycle counter equals TIMEOUT-1 with no store in that cycle, the FSM SHALL go to TOUT.
REQ-016 If a store and timeout expiry coincide, the store SHALL take priority (PASS/FAIL/count), and a count-only IGNORE_ADDR store SHALL give TOUT on the same edge.
REQ-017 PASS, FAIL and TOUT SHALL be terminal until reset.
REQ-018 In terminal states, en, MemWrite, DataAdr and WriteData SHALL be ignored and all outputs SHALL hold.
REQ-019 Deasserting en during RUN SHALL have no effect.
REQ-020 Outputs SHALL be registered and decoded from state: pass=PASS, fail=FAIL, timeout=TOUT, done=any terminal state.
REQ-021 Latency SHALL be one cycle: a verdict store sampled at edge N is visible on done/pass/fail directly after edge N.
REQ-022 Exactly one of pass, fail and timeout SHALL be high whenever done=1, and all three SHALL be 0 whenever done=0.

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE and zero done, pass, fail, timeout, store_count, fail_addr, fail_data and the cycle counter.
REQ-024 Reset SHALL override every other input, including en and a simultaneous store, in any state including mid-RUN.
REQ-025 Operation SHALL resume on the first edge with reset=0, which takes the IDLE branch of REQ-007.

Structure
REQ-026 Package store_monitor_pkg SHALL hold:
  - the state enum typedef (IDLE, RUN, PASS, FAIL, TOUT);
  - default constants DEF_PASS_ADDR, DEF_PASS_DATA, DEF_IGNORE_ADDR and DEF_TIMEOUT;
  - the widths CNT_W=16 and TMO_W=20.
REQ-027 One sub-module, sat_counter (parameterised width, with clear, increment and saturate), SHALL implement both store_count and the cycle counter.

Verification
REQ-028 Reset 3 cycles, en=1; stores (96,7), then (100,25) -> pass=1 and done=1 one cycle after the second store; store_count=2.
REQ-029 From RUN, store (104,25) -> fail=1, fail_addr=104, fail_data=25; a later store (100,25) leaves fail=1 and pass=0.
REQ-030 TIMEOUT=8, en=1, no stores -> timeout=1 and done=1 after exactly 8 RUN cycles; pass=0 and fail=0.
REQ-031 TIMEOUT=8 with store (100,25) on the 8th RUN cycle -> pass=1 and timeout=0; repeat with (96,1) on that cycle -> timeout=1 and store_count=1.
REQ-032 Store (100,25) while en=0 (IDLE) -> no verdict and store_count=0; then assert reset for one cycle in mid-RUN after 3 stores -> all outputs are 0 and the state is IDLE.
REQ-033 Force store_count to 16'hFFFE and drive three stores to 96 -> the count reads 16'hFFFF and holds with no wrap.
